internal_bus_hold_mux: RTL and testbench

Registered, parametrised successor to the combinational internal-bus source multiplexers in the 65C02 datapath. It selects one of SOURCES input words onto an internal bus under one-hot CNTL and registers the result. When no source is selected it either precharges the bus or holds the last value. When several sources are selected it resolves them as a wired-AND, as on the NMOS bus, and flags the event. One instance serves each internal bus: data-low, address-low and address-high.

---
 rtl/internal_bus_pkg.sv | 12 +
 rtl/bus_select_encoder.sv | 26 ++
 rtl/internal_bus_hold_mux.sv | 81 ++++++++
 tb/tb_internal_bus_hold_mux.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/internal_bus_pkg.sv
// Shared constants for the registered internal-bus source multiplexers.
// Used by the bus mux top and its select encoder.
package internal_bus_pkg;

    localparam int BUS_MODE_HOLD      = 0;
    localparam int BUS_MODE_PRECHARGE = 1;

    localparam int BUS_WIDTH_DEFAULT = 8;

    localparam logic [7:0] PRECHARGE_DEFAULT = 8'hFF;

endpackage

// File: rtl/bus_select_encoder.sv
// Combinational decode of the one-hot source select.
// Reports any/multi-hot and the lowest selected index.
module bus_select_encoder
    import internal_bus_pkg::*;
#(
    parameter int SOURCES = 4,
    parameter int IW      = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic [SOURCES-1:0] cntl,
    output logic               any,
    output logic               multi,
    output logic [IW-1:0]      idx
);

    assign any   = |cntl;
    assign multi = |(cntl & (cntl - SOURCES'(1)));

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int k = SOURCES - 1; k >= 0; k--) begin
            if (cntl[k]) idx = IW'(k);
        end
    end

endmodule

// File: rtl/internal_bus_hold_mux.sv
// Registered internal-bus source mux with hold/precharge on an idle bus
// and wired-AND resolution plus conflict tracking on multi-hot selects.
module internal_bus_hold_mux
    import internal_bus_pkg::*;
#(
    parameter int               WIDTH     = BUS_WIDTH_DEFAULT,
    parameter int               SOURCES   = 4,
    parameter int               MODE      = BUS_MODE_HOLD,
    parameter logic [WIDTH-1:0] PRECHARGE = {WIDTH{1'b1}},
    parameter int               IW        = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     EN,
    input  logic [SOURCES-1:0]       CNTL,
    input  logic [SOURCES*WIDTH-1:0] IN,
    input  logic                     CLR_CONFLICT,
    output logic [WIDTH-1:0]         OUT,
    output logic                     DRIVEN,
    output logic [IW-1:0]            SRC_ID,
    output logic                     CONFLICT,
    output logic [7:0]               CONFLICT_CNT
);

    logic          any;
    logic          multi;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] bus_and;

    bus_select_encoder #(
        .SOURCES (SOURCES),
        .IW      (IW)
    ) u_enc (
        .cntl  (CNTL),
        .any   (any),
        .multi (multi),
        .idx   (idx)
    );

    // Wired-AND of every selected source; a single select passes straight through
    always_comb begin
        bus_and = '1;
        for (int k = 0; k < SOURCES; k++) begin
            if (CNTL[k]) bus_and &= IN[k*WIDTH +: WIDTH];
        end
    end

    // Bus value, driven flag and source index
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT    <= PRECHARGE;
            DRIVEN <= 1'b0;
            SRC_ID <= '0;
        end else if (EN) begin
            if (any) begin
                OUT    <= bus_and;
                DRIVEN <= 1'b1;
                SRC_ID <= idx;
            end else begin
                if (MODE == BUS_MODE_PRECHARGE) OUT <= PRECHARGE;
                DRIVEN <= 1'b0;
                SRC_ID <= '0;
            end
        end
    end

    // Sticky conflict flag and saturating conflict counter; clear beats set
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            CONFLICT     <= 1'b0;
            CONFLICT_CNT <= 8'd0;
        end else if (CLR_CONFLICT) begin
            CONFLICT     <= 1'b0;
            CONFLICT_CNT <= 8'd0;
        end else if (EN && multi) begin
            CONFLICT <= 1'b1;
            if (CONFLICT_CNT != 8'hFF) CONFLICT_CNT <= CONFLICT_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_internal_bus_hold_mux.sv
// Directed bench for internal_bus_hold_mux.
// A hold-mode and a precharge-mode instance share all inputs.
module tb_internal_bus_hold_mux;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic [3:0]  CNTL;
    logic [7:0]  src [4];
    logic [31:0] in_bus;
    logic        CLR_CONFLICT;

    logic [7:0] out_h, out_p;
    logic       drv_h, drv_p;
    logic [1:0] id_h, id_p;
    logic       cf_h, cf_p;
    logic [7:0] cnt_h, cnt_p;

    int passed = 0;
    int total  = 0;

    assign in_bus = {src[3], src[2], src[1], src[0]};

    always #5 CLK = ~CLK;

    internal_bus_hold_mux #(.WIDTH(8), .SOURCES(4), .MODE(0)) u_hold (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .EN           (EN),
        .CNTL         (CNTL),
        .IN           (in_bus),
        .CLR_CONFLICT (CLR_CONFLICT),
        .OUT          (out_h),
        .DRIVEN       (drv_h),
        .SRC_ID       (id_h),
        .CONFLICT     (cf_h),
        .CONFLICT_CNT (cnt_h)
    );

    internal_bus_hold_mux #(.WIDTH(8), .SOURCES(4), .MODE(1)) u_pre (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .EN           (EN),
        .CNTL         (CNTL),
        .IN           (in_bus),
        .CLR_CONFLICT (CLR_CONFLICT),
        .OUT          (out_p),
        .DRIVEN       (drv_p),
        .SRC_ID       (id_p),
        .CONFLICT     (cf_p),
        .CONFLICT_CNT (cnt_p)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        EN = 1'b1;
        CNTL = 4'b0001;
        CLR_CONFLICT = 1'b0;
        cyc();
        cyc();
        total++;
        if (out_h !== 8'hFF) $display("FAIL reset_out_h got %h want ff", out_h);
        else passed++;
        total++;
        if (out_p !== 8'hFF) $display("FAIL reset_out_p got %h want ff", out_p);
        else passed++;
        total++;
        if ({drv_h, id_h, cf_h, cnt_h} !== 12'h0)
            $display("FAIL reset_state got %b%h%b%h want 0", drv_h, id_h, cf_h, cnt_h);
        else passed++;
    endtask

    task automatic test_walk();
        RST_N = 1'b1;
        EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CNTL = 4'b0001 << i;
            cyc();
            total++;
            if (out_h !== 8'(i + 1) || out_p !== 8'(i + 1))
                $display("FAIL walk_out%0d got %h/%h want %h", i, out_h, out_p, i + 1);
            else passed++;
            total++;
            if (id_h !== 2'(i) || drv_h !== 1'b1)
                $display("FAIL walk_id%0d got %0d drv %b want %0d drv 1", i, id_h, drv_h, i);
            else passed++;
        end
    endtask

    task automatic test_undriven();
        CNTL = 4'b0100;
        cyc();
        CNTL = 4'b0000;
        cyc();
        total++;
        if (out_h !== 8'h03 || drv_h !== 1'b0)
            $display("FAIL hold_idle got %h drv %b want 03 drv 0", out_h, drv_h);
        else passed++;
        total++;
        if (out_p !== 8'hFF || drv_p !== 1'b0)
            $display("FAIL precharge_idle got %h drv %b want ff drv 0", out_p, drv_p);
        else passed++;
        total++;
        if (id_h !== 2'd0 || id_p !== 2'd0)
            $display("FAIL idle_id got %0d/%0d want 0", id_h, id_p);
        else passed++;
    endtask

    task automatic test_conflict();
        CNTL = 4'b0110;
        cyc();
        total++;
        if (out_h !== 8'h02 || id_h !== 2'd1)
            $display("FAIL conflict_out got %h id %0d want 02 id 1", out_h, id_h);
        else passed++;
        total++;
        if (cf_h !== 1'b1 || cnt_h !== 8'd1)
            $display("FAIL conflict_flag got %b cnt %0d want 1 cnt 1", cf_h, cnt_h);
        else passed++;
        CNTL = 4'b1111;
        for (int n = 1; n <= 300; n++) begin
            cyc();
            if (n == 10) begin
                total++;
                if (cnt_h !== 8'd11) $display("FAIL cnt_10 got %0d want 11", cnt_h);
                else passed++;
            end
            if (n == 253) begin
                total++;
                if (cnt_h !== 8'd254) $display("FAIL cnt_253 got %0d want 254", cnt_h);
                else passed++;
            end
            if (n == 254) begin
                total++;
                if (cnt_h !== 8'd255) $display("FAIL cnt_254 got %0d want 255", cnt_h);
                else passed++;
            end
        end
        total++;
        if (cnt_h !== 8'd255 || cnt_p !== 8'd255)
            $display("FAIL cnt_sat got %0d/%0d want 255", cnt_h, cnt_p);
        else passed++;
        total++;
        if (out_h !== 8'h00 || id_h !== 2'd0 || drv_h !== 1'b1)
            $display("FAIL and_all got %h id %0d drv %b want 00 id 0 drv 1", out_h, id_h, drv_h);
        else passed++;
    endtask

    task automatic test_clear();
        CNTL = 4'b0011;
        CLR_CONFLICT = 1'b1;
        cyc();
        CLR_CONFLICT = 1'b0;
        total++;
        if (out_h !== 8'h00 || cf_h !== 1'b0 || cnt_h !== 8'd0)
            $display("FAIL clear_wins got %h cf %b cnt %0d want 00 0 0", out_h, cf_h, cnt_h);
        else passed++;
    endtask

    task automatic test_en_hold();
        CNTL = 4'b0110;
        cyc();
        EN = 1'b0;
        CNTL = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            src[3] = 8'hA0 + 8'(i);
            cyc();
            total++;
            if (out_h !== 8'h02 || id_h !== 2'd1 || drv_h !== 1'b1)
                $display("FAIL en_hold%0d got %h id %0d drv %b want 02 1 1", i, out_h, id_h, drv_h);
            else passed++;
            total++;
            if (cf_h !== 1'b1 || cnt_h !== 8'd1)
                $display("FAIL en_hold_cf%0d got %b cnt %0d want 1 1", i, cf_h, cnt_h);
            else passed++;
        end
        CLR_CONFLICT = 1'b1;
        cyc();
        CLR_CONFLICT = 1'b0;
        total++;
        if (cf_h !== 1'b0 || cnt_h !== 8'd0 || out_h !== 8'h02)
            $display("FAIL en0_clear got cf %b cnt %0d out %h want 0 0 02", cf_h, cnt_h, out_h);
        else passed++;
        src[3] = 8'h04;
    endtask

    task automatic test_reset_mid();
        EN = 1'b1;
        CNTL = 4'b1100;
        cyc();
        CNTL = 4'b1000;
        cyc();
        total++;
        if (out_h !== 8'h04 || cf_h !== 1'b1)
            $display("FAIL pre_reset got %h cf %b want 04 1", out_h, cf_h);
        else passed++;
        RST_N = 1'b0;
        cyc();
        total++;
        if (out_h !== 8'hFF || drv_h !== 1'b0 || id_h !== 2'd0)
            $display("FAIL mid_reset got %h drv %b id %0d want ff 0 0", out_h, drv_h, id_h);
        else passed++;
        total++;
        if (cf_h !== 1'b0 || cnt_h !== 8'd0)
            $display("FAIL mid_reset_cf got %b cnt %0d want 0 0", cf_h, cnt_h);
        else passed++;
        RST_N = 1'b1;
    endtask

    initial begin
        src[0] = 8'h01;
        src[1] = 8'h02;
        src[2] = 8'h03;
        src[3] = 8'h04;
        test_reset();
        test_walk();
        test_undriven();
        test_conflict();
        test_clear();
        test_en_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
